// File: rtl/clock_chain_ctrl.sv
// Sequencing controller for the cascaded sec/min/hr counters: 1 Hz carry/wrap strobes plus set-time mode FSM.
// Optional blink output when CLOCK_CHAIN_BLINK_EN is defined.
module clock_chain_ctrl #(
    parameter int W       = 6,
    parameter int SEC_MAX = 59,
    parameter int MIN_MAX = 59,
    parameter int HR_MAX  = 23
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick_1hz,
    input  logic         btn_mode,
    input  logic         btn_adv,
    input  logic [W-1:0] sec_q,
    input  logic [W-1:0] min_q,
    input  logic [W-1:0] hr_q,
    output logic         sec_ce,
    output logic         sec_ld,
    output logic         min_ce,
    output logic         min_ld,
    output logic         hr_ce,
    output logic         hr_ld,
    output logic         day_wrap,
    output logic [1:0]   mode
`ifdef CLOCK_CHAIN_BLINK_EN
    ,
    output logic         blink
`endif
);

    localparam logic [1:0] MODE_RUN     = 2'd0;
    localparam logic [1:0] MODE_SET_HR  = 2'd1;
    localparam logic [1:0] MODE_SET_MIN = 2'd2;

    localparam int B_SEC_CE = 0;
    localparam int B_SEC_LD = 1;
    localparam int B_MIN_CE = 2;
    localparam int B_MIN_LD = 3;
    localparam int B_HR_CE  = 4;
    localparam int B_HR_LD  = 5;
    localparam int B_DAY    = 6;

    localparam logic [W-1:0] L_SEC_MAX = W'(SEC_MAX);
    localparam logic [W-1:0] L_MIN_MAX = W'(MIN_MAX);
    localparam logic [W-1:0] L_HR_MAX  = W'(HR_MAX);

    logic [6:0] r_str;
    logic [1:0] r_mode;
    logic       r_pend;

    logic [6:0] w_str_next;
    logic [1:0] w_mode_next;
    logic       w_tick;
    logic       w_adv;
    logic       w_sec_top;
    logic       w_min_top;
    logic       w_hr_top;

    // While a strobe is in flight the counter q values are stale, so ticks/advances are dropped.
    assign w_tick    = tick_1hz & ~r_pend;
    assign w_adv     = btn_adv & ~r_pend;
    assign w_sec_top = (sec_q >= L_SEC_MAX);
    assign w_min_top = (min_q >= L_MIN_MAX);
    assign w_hr_top  = (hr_q >= L_HR_MAX);

    always_comb begin
        w_str_next  = '0;
        w_mode_next = r_mode;
        case (r_mode)
            MODE_RUN: begin
                if (w_tick) begin
                    w_str_next[B_SEC_CE] = 1'b1;
                    if (w_sec_top) begin
                        w_str_next[B_SEC_LD] = 1'b1;
                        w_str_next[B_MIN_CE] = 1'b1;
                        if (w_min_top) begin
                            w_str_next[B_MIN_LD] = 1'b1;
                            w_str_next[B_HR_CE]  = 1'b1;
                            if (w_hr_top) begin
                                w_str_next[B_HR_LD] = 1'b1;
                                w_str_next[B_DAY]   = 1'b1;
                            end
                        end
                    end
                end
                if (btn_mode) begin
                    w_mode_next = MODE_SET_HR;
                end
            end
            MODE_SET_HR: begin
                if (btn_mode) begin
                    w_mode_next = MODE_SET_MIN;
                end else if (w_adv) begin
                    w_str_next[B_HR_CE] = 1'b1;
                    w_str_next[B_HR_LD] = w_hr_top;
                end
            end
            MODE_SET_MIN: begin
                // Leaving set mode clears the seconds, even while a strobe is pending.
                if (btn_mode) begin
                    w_mode_next          = MODE_RUN;
                    w_str_next[B_SEC_CE] = 1'b1;
                    w_str_next[B_SEC_LD] = 1'b1;
                end else if (w_adv) begin
                    w_str_next[B_MIN_CE] = 1'b1;
                    w_str_next[B_MIN_LD] = w_min_top;
                end
            end
            default: begin
                w_mode_next = MODE_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_str  <= '0;
            r_mode <= MODE_RUN;
            r_pend <= 1'b0;
        end else begin
            r_str  <= w_str_next;
            r_mode <= w_mode_next;
            r_pend <= |w_str_next;
        end
    end

    assign sec_ce   = r_str[B_SEC_CE];
    assign sec_ld   = r_str[B_SEC_LD];
    assign min_ce   = r_str[B_MIN_CE];
    assign min_ld   = r_str[B_MIN_LD];
    assign hr_ce    = r_str[B_HR_CE];
    assign hr_ld    = r_str[B_HR_LD];
    assign day_wrap = r_str[B_DAY];
    assign mode     = r_mode;

`ifdef CLOCK_CHAIN_BLINK_EN
    logic r_blink;
    logic w_blink_next;
    logic w_in_set;

    assign w_in_set = (r_mode == MODE_SET_HR) || (r_mode == MODE_SET_MIN);

    always_comb begin
        w_blink_next = r_blink;
        if (w_mode_next == MODE_RUN) begin
            w_blink_next = 1'b0;
        end else if (tick_1hz && w_in_set) begin
            w_blink_next = ~r_blink;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink <= 1'b0;
        end else begin
            r_blink <= w_blink_next;
        end
    end

    assign blink = r_blink;
`endif

endmodule

// File: tb/tb_clock_chain_ctrl.sv
// Self-checking bench for clock_chain_ctrl: directed scenarios plus randomized cycles against a time-of-day model.
module tb_clock_chain_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz;
    logic       btn_mode;
    logic       btn_adv;
    logic [5:0] sec_q;
    logic [5:0] min_q;
    logic [5:0] hr_q;
    logic       sec_ce, sec_ld, min_ce, min_ld, hr_ce, hr_ld, day_wrap;
    logic [1:0] mode;
`ifdef CLOCK_CHAIN_BLINK_EN
    logic       blink;
`endif

    logic [6:0] obs_str;
    assign obs_str = {day_wrap, hr_ld, hr_ce, min_ld, min_ce, sec_ld, sec_ce};

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         m_mode;
    bit         m_pend;
    bit         m_blink;
    logic [6:0] exp_str;

    clock_chain_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .tick_1hz (tick_1hz),
        .btn_mode (btn_mode),
        .btn_adv  (btn_adv),
        .sec_q    (sec_q),
        .min_q    (min_q),
        .hr_q     (hr_q),
        .sec_ce   (sec_ce),
        .sec_ld   (sec_ld),
        .min_ce   (min_ce),
        .min_ld   (min_ld),
        .hr_ce    (hr_ce),
        .hr_ld    (hr_ld),
        .day_wrap (day_wrap),
        .mode     (mode)
`ifdef CLOCK_CHAIN_BLINK_EN
        ,
        .blink    (blink)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode  = 0;
        m_pend  = 0;
        m_blink = 0;
        exp_str = '0;
    endtask

    // Field f (0=sec,1=min,2=hr) counts when all lower fields wrap; it wraps when it too is at max.
    task automatic model_step(input bit t, input bit bm, input bit ba, input int s, input int mi, input int h);
        int n_wrap;
        int nxt;
        exp_str = '0;
        nxt = bm ? (m_mode + 1) % 3 : m_mode;
        if (m_mode == 0) begin
            if (t && !m_pend) begin
                n_wrap = (s >= 59) ? ((mi >= 59) ? ((h >= 23) ? 3 : 2) : 1) : 0;
                for (int f = 0; f < 3; f++) begin
                    if (f <= n_wrap) exp_str[2*f] = 1'b1;
                    if (f < n_wrap)  exp_str[2*f+1] = 1'b1;
                end
                if (n_wrap == 3) exp_str[6] = 1'b1;
            end
        end else if (m_mode == 1) begin
            if (ba && !bm && !m_pend) begin
                exp_str[4] = 1'b1;
                exp_str[5] = (h >= 23);
            end
        end else begin
            if (bm) begin
                exp_str[0] = 1'b1;
                exp_str[1] = 1'b1;
            end else if (ba && !m_pend) begin
                exp_str[2] = 1'b1;
                exp_str[3] = (mi >= 59);
            end
        end
        if (nxt == 0) m_blink = 0;
        else if (t && m_mode != 0) m_blink = !m_blink;
        m_mode = nxt;
        m_pend = (exp_str != 0);
    endtask

    task automatic drive_cycle(input bit t, input bit bm, input bit ba, input int s, input int mi, input int h);
        tick_1hz = t;
        btn_mode = bm;
        btn_adv  = ba;
        sec_q    = 6'(s);
        min_q    = 6'(mi);
        hr_q     = 6'(h);
        @(posedge clk);
        model_step(t, bm, ba, s, mi, h);
        #1;
        tick_1hz = 1'b0;
        btn_mode = 1'b0;
        btn_adv  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        tick_1hz = 0; btn_mode = 0; btn_adv = 0;
        sec_q = 0; min_q = 0; hr_q = 0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs_str !== 7'b0 || mode !== 2'd0) begin
            errors++;
            $display("FAIL reset: strobes=%b mode=%0d expected strobes=0000000 mode=0", obs_str, mode);
        end
`ifdef CLOCK_CHAIN_BLINK_EN
        checks++;
        if (blink !== 1'b0) begin
            errors++;
            $display("FAIL reset_blink: blink=%b expected 0", blink);
        end
`endif
        rst = 1'b0;
        $display("reset: strobes=%b mode=%0d", obs_str, mode);
    endtask

    task automatic test_tick_basic();
        do_reset();
        drive_cycle(1, 0, 0, 58, 10, 5);
        checks++;
        if (obs_str !== exp_str || obs_str !== 7'b0000001 || mode !== 2'd0) begin
            errors++;
            $display("FAIL tick_basic: strobes=%b mode=%0d expected %b mode=0", obs_str, mode, exp_str);
        end
        $display("tick_basic: strobes=%b mode=%0d", obs_str, mode);
        drive_cycle(0, 0, 0, 59, 10, 5);
        checks++;
        if (obs_str !== 7'b0) begin
            errors++;
            $display("FAIL tick_one_cycle: strobes=%b expected 0000000", obs_str);
        end
    endtask

    task automatic test_day_wrap();
        do_reset();
        drive_cycle(1, 0, 0, 59, 59, 23);
        checks++;
        if (obs_str !== exp_str || obs_str !== 7'b1111111) begin
            errors++;
            $display("FAIL day_wrap: strobes=%b expected %b", obs_str, exp_str);
        end
        $display("day_wrap: strobes=%b", obs_str);
        drive_cycle(0, 0, 0, 0, 0, 0);
        checks++;
        if (obs_str !== 7'b0) begin
            errors++;
            $display("FAIL day_wrap_one_cycle: strobes=%b expected 0000000", obs_str);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive_cycle(1, 0, 0, 12, 0, 0);
        checks++;
        if (obs_str !== exp_str) begin
            errors++;
            $display("FAIL b2b_first: strobes=%b expected %b", obs_str, exp_str);
        end
        drive_cycle(1, 0, 0, 12, 0, 0);
        checks++;
        if (obs_str !== exp_str || sec_ce !== 1'b0) begin
            errors++;
            $display("FAIL b2b_dropped: strobes=%b expected %b", obs_str, exp_str);
        end
        drive_cycle(1, 0, 0, 13, 0, 0);
        checks++;
        if (obs_str !== exp_str || sec_ce !== 1'b1) begin
            errors++;
            $display("FAIL b2b_third: strobes=%b expected %b", obs_str, exp_str);
        end
        $display("back_to_back: strobes=%b", obs_str);
    endtask

    task automatic test_set_hr();
        do_reset();
        drive_cycle(0, 1, 0, 0, 0, 0);
        checks++;
        if (mode !== 2'd1 || obs_str !== 7'b0) begin
            errors++;
            $display("FAIL set_hr_enter: mode=%0d strobes=%b expected mode=1 strobes=0000000", mode, obs_str);
        end
        drive_cycle(0, 0, 1, 20, 59, 23);
        checks++;
        if (obs_str !== exp_str || obs_str !== 7'b0110000) begin
            errors++;
            $display("FAIL set_hr_adv: strobes=%b expected %b", obs_str, exp_str);
        end
        drive_cycle(0, 0, 0, 20, 59, 0);
        drive_cycle(1, 0, 0, 59, 59, 23);
        checks++;
        if (obs_str !== 7'b0 || mode !== 2'd1) begin
            errors++;
            $display("FAIL set_hr_tick_ignored: strobes=%b mode=%0d expected 0000000 mode=1", obs_str, mode);
        end
        $display("set_hr: strobes=%b mode=%0d", obs_str, mode);
    endtask

    task automatic test_set_min_exit();
        do_reset();
        drive_cycle(0, 1, 0, 0, 0, 0);
        drive_cycle(0, 1, 0, 0, 0, 0);
        checks++;
        if (mode !== 2'd2) begin
            errors++;
            $display("FAIL set_min_enter: mode=%0d expected 2", mode);
        end
        drive_cycle(0, 1, 1, 30, 59, 23);
        checks++;
        if (obs_str !== exp_str || obs_str !== 7'b0000011 || mode !== 2'd0) begin
            errors++;
            $display("FAIL set_min_exit: strobes=%b mode=%0d expected %b mode=0", obs_str, mode, exp_str);
        end
        $display("set_min_exit: strobes=%b mode=%0d", obs_str, mode);
    endtask

    task automatic test_async_reset();
        do_reset();
        drive_cycle(0, 1, 0, 0, 0, 0);
        drive_cycle(1, 0, 0, 0, 0, 0);
        drive_cycle(0, 0, 1, 0, 0, 23);
        checks++;
        if (obs_str !== exp_str || hr_ce !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre: strobes=%b expected %b", obs_str, exp_str);
        end
        #1 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (obs_str !== 7'b0 || mode !== 2'd0) begin
            errors++;
            $display("FAIL arst_immediate: strobes=%b mode=%0d expected 0000000 mode=0", obs_str, mode);
        end
`ifdef CLOCK_CHAIN_BLINK_EN
        checks++;
        if (blink !== 1'b0) begin
            errors++;
            $display("FAIL arst_blink: blink=%b expected 0", blink);
        end
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        drive_cycle(0, 0, 0, 59, 59, 23);
        checks++;
        if (obs_str !== 7'b0) begin
            errors++;
            $display("FAIL arst_after: strobes=%b expected 0000000", obs_str);
        end
        $display("async_reset: strobes=%b mode=%0d", obs_str, mode);
    endtask

`ifdef CLOCK_CHAIN_BLINK_EN
    task automatic test_blink();
        bit exp_b;
        do_reset();
        drive_cycle(0, 1, 0, 0, 0, 0);
        exp_b = 0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (blink !== exp_b) begin
                errors++;
                $display("FAIL blink_step%0d: blink=%b expected %b", i, blink, exp_b);
            end
            $display("blink step %0d: blink=%b", i, blink);
            drive_cycle(1, 0, 0, 0, 0, 0);
            exp_b = !exp_b;
        end
        drive_cycle(0, 1, 0, 0, 0, 0);
        drive_cycle(0, 1, 0, 0, 0, 0);
        checks++;
        if (blink !== 1'b0 || mode !== 2'd0) begin
            errors++;
            $display("FAIL blink_run: blink=%b mode=%0d expected 0 mode=0", blink, mode);
        end
    endtask
`endif

    task automatic test_random();
        int s, mi, h;
        bit t, bm, ba;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            t  = ($urandom_range(0, 2) == 0);
            bm = ($urandom_range(0, 7) == 0);
            ba = ($urandom_range(0, 2) == 0);
            s  = $urandom_range(55, 63);
            mi = $urandom_range(56, 63);
            h  = $urandom_range(20, 30);
            drive_cycle(t, bm, ba, s, mi, h);
            checks++;
            if (obs_str !== exp_str || mode !== 2'(m_mode)) begin
                errors++;
                $display("FAIL random[%0d]: strobes=%b mode=%0d expected %b mode=%0d", i, obs_str, mode, exp_str, m_mode);
            end
`ifdef CLOCK_CHAIN_BLINK_EN
            checks++;
            if (blink !== m_blink) begin
                errors++;
                $display("FAIL random_blink[%0d]: blink=%b expected %b", i, blink, m_blink);
            end
`endif
        end
        $display("random: 600 cycles done");
    endtask

    // Emulates the counter datapath and checks time of day advances by one second per accepted tick.
    task automatic test_counting();
        int cs, cm, ch, start, now, wraps, exp_wraps;
        do_reset();
        start = 86400 - 1 - $urandom_range(0, 20);
        cs = start % 60;
        cm = (start / 60) % 60;
        ch = start / 3600;
        wraps = 0;
        for (int n = 1; n <= 40; n++) begin
            drive_cycle(1, 0, 0, cs, cm, ch);
            checks++;
            if (obs_str !== exp_str) begin
                errors++;
                $display("FAIL count_strobes[%0d]: strobes=%b expected %b", n, obs_str, exp_str);
            end
            if (day_wrap) wraps++;
            if (sec_ce) cs = sec_ld ? 0 : cs + 1;
            if (min_ce) cm = min_ld ? 0 : cm + 1;
            if (hr_ce)  ch = hr_ld ? 0 : ch + 1;
            drive_cycle(0, 0, 0, cs, cm, ch);
            drive_cycle(0, 0, 0, cs, cm, ch);
            now = ch * 3600 + cm * 60 + cs;
            checks++;
            if (now !== (start + n) % 86400) begin
                errors++;
                $display("FAIL count_time[%0d]: time=%0d expected %0d", n, now, (start + n) % 86400);
            end
        end
        exp_wraps = (start + 40 >= 86400) ? 1 : 0;
        checks++;
        if (wraps !== exp_wraps) begin
            errors++;
            $display("FAIL count_wraps: day_wrap pulses=%0d expected %0d", wraps, exp_wraps);
        end
        $display("counting: start=%0d end=%0d wraps=%0d", start, ch * 3600 + cm * 60 + cs, wraps);
    endtask

    initial begin
        test_reset();
        test_tick_basic();
        test_day_wrap();
        test_back_to_back();
        test_set_hr();
        test_set_min_exit();
        test_async_reset();
`ifdef CLOCK_CHAIN_BLINK_EN
        test_blink();
`endif
        test_random();
        test_counting();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
